// File: rtl/waw_pkg.sv
// Shared definitions for the write-after-write tracking FIFO and its writeback consumer.
// Ports: none (package only): tracking-entry layout, widths, controller state encoding.
// Hit function: matches the two younger-writer issue strobes against a destination register.
package waw_pkg;

  localparam int RegAddrW   = 5;
  localparam int TrkW       = 6;
  localparam int WawLiveBit = 5;

  // One tracking entry: live flag above the destination register address.
  typedef struct packed {
    logic                live;
    logic [RegAddrW-1:0] addr;
  } trk_entry_t;

  // Writeback controller: either nothing held, or one entry waiting to retire.
  typedef enum logic {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } wb_state_t;

  // True when either younger writer issued this cycle targets addr.
  function automatic logic waw_hit(
    input logic [1:0]          req,
    input logic [RegAddrW-1:0] a0,
    input logic [RegAddrW-1:0] a1,
    input logic [RegAddrW-1:0] addr
  );
    return (req[0] && (a0 == addr)) || (req[1] && (a1 == addr));
  endfunction

endpackage

// File: rtl/waw_wb_ctrl.sv
// Pairs popped WaW tracking entries with in-order result responses in a one-entry hold register.
// Ports: tracking pop (trk_*), response accept (resp_*), younger-writer strobes (waw_*), RF write (rf_*), scoreboard release (sb_*), err_o.
// Latency: accept in N, write request / suppressed retire in N+1; 1/cycle with grant held high, pops stall while a write waits.
module waw_wb_ctrl
  import waw_pkg::*;
#(
  parameter int DataW = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  input  logic                trk_valid_i,
  input  logic [TrkW-1:0]     trk_data_i,
  output logic                trk_rdy_o,
  input  logic                resp_valid_i,
  input  logic [DataW-1:0]    resp_data_i,
  input  logic                resp_err_i,
  output logic                resp_rdy_o,
  input  logic [1:0]          waw_req_i,
  input  logic [RegAddrW-1:0] waw_addr0_i,
  input  logic [RegAddrW-1:0] waw_addr1_i,
  output logic                rf_we_o,
  output logic [RegAddrW-1:0] rf_waddr_o,
  output logic [DataW-1:0]    rf_wdata_o,
  input  logic                rf_gnt_i,
  output logic                sb_clr_o,
  output logic [RegAddrW-1:0] sb_clr_addr_o,
  output logic                err_o
);

  wb_state_t           state_q, state_d;
  trk_entry_t          trk_in;

  // Hold register
  logic                live_q;
  logic [RegAddrW-1:0] addr_q;
  logic [DataW-1:0]    data_q;
  logic                err_q;

  logic                held;
  logic                need_wr;
  logic                retire;
  logic                accept;
  logic                hold_hit;
  logic                in_hit;

  assign trk_in = trk_entry_t'(trk_data_i);
  assign held   = (state_q == HOLD);

  // Only a live, error-free entry with a real destination (r0 excluded) writes.
  assign need_wr = live_q && !err_q && (addr_q != '0);

  // Suppressed entries leave without waiting for a grant. A flush cycle never
  // retires (a grant seen then is ignored), and a reset cycle never retires so
  // a discarded entry issues no release pulse.
  assign retire = rst_ni && !flush_i && held && (need_wr ? rf_gnt_i : 1'b1);

  // Both sides pop together; a free slot exists when empty or when the held
  // entry retires this cycle, giving one entry per cycle under a held grant.
  assign accept = rst_ni && !flush_i && trk_valid_i && resp_valid_i && (!held || retire);

  // Same clearing rule the FIFO applies, checked against the held entry and
  // against the entry arriving this cycle (which the FIFO no longer sees).
  assign hold_hit = waw_hit(waw_req_i, waw_addr0_i, waw_addr1_i, addr_q);
  assign in_hit   = waw_hit(waw_req_i, waw_addr0_i, waw_addr1_i, trk_in.addr);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = EMPTY;
    end else if (accept) begin
      state_d = HOLD;
    end else if (retire) begin
      state_d = EMPTY;
    end
  end

  // ---------------------------------------------------------------------------
  // Hold register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      live_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
    end else if (accept) begin
      live_q <= trk_in.live && !in_hit;
      addr_q <= trk_in.addr;
      data_q <= resp_data_i;
      err_q  <= resp_err_i;
    end else if (held && !retire && !flush_i) begin
      // A superseded waiting entry drops its write; it then retires next cycle.
      live_q <= live_q && !hold_hit;
    end
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    trk_rdy_o     = accept;
    resp_rdy_o    = accept;
    rf_we_o       = held && need_wr;
    rf_waddr_o    = addr_q;
    rf_wdata_o    = data_q;
    // Errored live entries still free their scoreboard bit.
    sb_clr_o      = retire && live_q && (addr_q != '0);
    sb_clr_addr_o = addr_q;
    err_o         = retire && err_q;
  end

endmodule

// File: tb/tb_waw_wb_ctrl.sv
// Directed bench for waw_wb_ctrl: per-cycle vector table plus back-to-back and hold-supersede sequences.
module tb_waw_wb_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_i;
  logic        trk_valid_i;
  logic [5:0]  trk_data_i;
  logic        trk_rdy_o;
  logic        resp_valid_i;
  logic [31:0] resp_data_i;
  logic        resp_err_i;
  logic        resp_rdy_o;
  logic [1:0]  waw_req_i;
  logic [4:0]  waw_addr0_i;
  logic [4:0]  waw_addr1_i;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic        rf_gnt_i;
  logic        sb_clr_o;
  logic [4:0]  sb_clr_addr_o;
  logic        err_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  waw_wb_ctrl #(.DataW(32)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .flush_i       (flush_i),
    .trk_valid_i   (trk_valid_i),
    .trk_data_i    (trk_data_i),
    .trk_rdy_o     (trk_rdy_o),
    .resp_valid_i  (resp_valid_i),
    .resp_data_i   (resp_data_i),
    .resp_err_i    (resp_err_i),
    .resp_rdy_o    (resp_rdy_o),
    .waw_req_i     (waw_req_i),
    .waw_addr0_i   (waw_addr0_i),
    .waw_addr1_i   (waw_addr1_i),
    .rf_we_o       (rf_we_o),
    .rf_waddr_o    (rf_waddr_o),
    .rf_wdata_o    (rf_wdata_o),
    .rf_gnt_i      (rf_gnt_i),
    .sb_clr_o      (sb_clr_o),
    .sb_clr_addr_o (sb_clr_addr_o),
    .err_o         (err_o)
  );

  typedef struct packed {
    logic        rst_n;
    logic        flush;
    logic        tv;
    logic [5:0]  td;
    logic        rv;
    logic [31:0] rd;
    logic        re;
    logic [1:0]  wr;
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic        gnt;
  } ins_t;

  typedef struct packed {
    logic        rdy;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        clr;
    logic [4:0]  ca;
    logic        err;
  } outs_t;

  typedef struct packed {
    ins_t  i;
    outs_t e;
    logic  full;  // compare address/data fields even when their strobe is low
  } vec_t;

  function automatic vec_t mkv(
    input logic rst_n, input logic flush, input logic tv, input logic [5:0] td,
    input logic rv, input logic [31:0] rd, input logic re, input logic [1:0] wr,
    input logic [4:0] a0, input logic [4:0] a1, input logic gnt,
    input logic e_rdy, input logic e_we, input logic [4:0] e_wa, input logic [31:0] e_wd,
    input logic e_clr, input logic [4:0] e_ca, input logic e_err, input logic full
  );
    vec_t v;
    v.i = '{rst_n, flush, tv, td, rv, rd, re, wr, a0, a1, gnt};
    v.e = '{e_rdy, e_we, e_wa, e_wd, e_clr, e_ca, e_err};
    v.full = full;
    return v;
  endfunction

  // Drive one cycle of inputs, compare outputs at the falling edge, then clock.
  task automatic step(input string name, input vec_t v);
    outs_t a;
    outs_t e;
    rst_ni       = v.i.rst_n;
    flush_i      = v.i.flush;
    trk_valid_i  = v.i.tv;
    trk_data_i   = v.i.td;
    resp_valid_i = v.i.rv;
    resp_data_i  = v.i.rd;
    resp_err_i   = v.i.re;
    waw_req_i    = v.i.wr;
    waw_addr0_i  = v.i.a0;
    waw_addr1_i  = v.i.a1;
    rf_gnt_i     = v.i.gnt;
    @(negedge clk_i);
    e = v.e;
    a = '{trk_rdy_o, rf_we_o, rf_waddr_o, rf_wdata_o, sb_clr_o, sb_clr_addr_o, err_o};
    if (!v.full) begin
      if (!e.we) begin
        e.wa = '0; e.wd = '0; a.wa = '0; a.wd = '0;
      end
      if (!e.clr) begin
        e.ca = '0; a.ca = '0;
      end
    end
    checks++;
    if (a !== e || resp_rdy_o !== trk_rdy_o) begin
      failures++;
      $display("FAIL %s got rdy=%b/%b we=%b wa=%0d wd=%h clr=%b ca=%0d err=%b want rdy=%b we=%b wa=%0d wd=%h clr=%b ca=%0d err=%b",
               name, a.rdy, resp_rdy_o, a.we, a.wa, a.wd, a.clr, a.ca, a.err,
               e.rdy, e.we, e.wa, e.wd, e.clr, e.ca, e.err);
    end
    @(posedge clk_i);
    #1;
  endtask

  vec_t tbl[19];

  initial begin
    // in: rst flush tv td rv rd re wr a0 a1 gnt | exp: rdy we wa wd clr ca err | full
    tbl[0]  = mkv(1'b1,1'b0,1'b0,6'h00,1'b0,32'h0,1'b0,2'b00,5'd0,5'd0,1'b0, 1'b0,1'b0,5'd0,32'h0,1'b0,5'd0,1'b0, 1'b1);
    // basic write to r7
    tbl[1]  = mkv(1'b1,1'b0,1'b1,6'h27,1'b1,32'hDEADBEEF,1'b0,2'b00,5'd0,5'd0,1'b1, 1'b1,1'b0,5'd0,32'h0,1'b0,5'd0,1'b0, 1'b0);
    tbl[2]  = mkv(1'b1,1'b0,1'b0,6'h00,1'b0,32'h0,1'b0,2'b00,5'd0,5'd0,1'b1, 1'b0,1'b1,5'd7,32'hDEADBEEF,1'b1,5'd7,1'b0, 1'b0);
    // superseded entry, next entry (errored r4) accepted in its retire cycle
    tbl[3]  = mkv(1'b1,1'b0,1'b1,6'h03,1'b1,32'h11111111,1'b0,2'b00,5'd0,5'd0,1'b0, 1'b1,1'b0,5'd0,32'h0,1'b0,5'd0,1'b0, 1'b0);
    tbl[4]  = mkv(1'b1,1'b0,1'b1,6'h24,1'b1,32'hBAD0BAD0,1'b1,2'b00,5'd0,5'd0,1'b0, 1'b1,1'b0,5'd0,32'h0,1'b0,5'd0,1'b0, 1'b0);
    tbl[5]  = mkv(1'b1,1'b0,1'b0,6'h00,1'b0,32'h0,1'b0,2'b00,5'd0,5'd0,1'b0, 1'b0,1'b0,5'd0,32'h0,1'b1,5'd4,1'b1, 1'b0);
    tbl[6]  = mkv(1'b1,1'b0,1'b0,6'h00,1'b0,32'h0,1'b0,2'b00,5'd0,5'd0,1'b0, 1'b0,1'b0,5'd0,32'h0,1'b0,5'd0,1'b0, 1'b0);
    // flush while holding r12 with grant high
    tbl[7]  = mkv(1'b1,1'b0,1'b1,6'h2C,1'b1,32'h0C0C0C0C,1'b0,2'b00,5'd0,5'd0,1'b1, 1'b1,1'b0,5'd0,32'h0,1'b0,5'd0,1'b0, 1'b0);
    tbl[8]  = mkv(1'b1,1'b1,1'b1,6'h2D,1'b1,32'h0D0D0D0D,1'b0,2'b00,5'd0,5'd0,1'b1, 1'b0,1'b1,5'd12,32'h0C0C0C0C,1'b0,5'd0,1'b0, 1'b0);
    tbl[9]  = mkv(1'b1,1'b0,1'b0,6'h00,1'b0,32'h0,1'b0,2'b00,5'd0,5'd0,1'b1, 1'b0,1'b0,5'd0,32'h0,1'b0,5'd0,1'b0, 1'b0);
    // reset while holding r12
    tbl[10] = mkv(1'b1,1'b0,1'b1,6'h2C,1'b1,32'h0C0C0C0C,1'b0,2'b00,5'd0,5'd0,1'b0, 1'b1,1'b0,5'd0,32'h0,1'b0,5'd0,1'b0, 1'b0);
    tbl[11] = mkv(1'b0,1'b0,1'b0,6'h00,1'b0,32'h0,1'b0,2'b00,5'd0,5'd0,1'b0, 1'b0,1'b1,5'd12,32'h0C0C0C0C,1'b0,5'd0,1'b0, 1'b0);
    tbl[12] = mkv(1'b1,1'b0,1'b0,6'h00,1'b0,32'h0,1'b0,2'b00,5'd0,5'd0,1'b1, 1'b0,1'b0,5'd0,32'h0,1'b0,5'd0,1'b0, 1'b1);
    // incoming entry superseded in its own accept cycle
    tbl[13] = mkv(1'b1,1'b0,1'b1,6'h26,1'b1,32'h0000600D,1'b0,2'b01,5'd6,5'd0,1'b1, 1'b1,1'b0,5'd0,32'h0,1'b0,5'd0,1'b0, 1'b0);
    tbl[14] = mkv(1'b1,1'b0,1'b0,6'h00,1'b0,32'h0,1'b0,2'b00,5'd0,5'd0,1'b1, 1'b0,1'b0,5'd0,32'h0,1'b0,5'd0,1'b0, 1'b0);
    // live entry to r0: no write, no release
    tbl[15] = mkv(1'b1,1'b0,1'b1,6'h20,1'b1,32'h12345678,1'b0,2'b00,5'd0,5'd0,1'b0, 1'b1,1'b0,5'd0,32'h0,1'b0,5'd0,1'b0, 1'b0);
    tbl[16] = mkv(1'b1,1'b0,1'b0,6'h00,1'b0,32'h0,1'b0,2'b00,5'd0,5'd0,1'b0, 1'b0,1'b0,5'd0,32'h0,1'b0,5'd0,1'b0, 1'b0);
    // one-sided valids never pop
    tbl[17] = mkv(1'b1,1'b0,1'b1,6'h21,1'b0,32'h0,1'b0,2'b00,5'd0,5'd0,1'b1, 1'b0,1'b0,5'd0,32'h0,1'b0,5'd0,1'b0, 1'b0);
    tbl[18] = mkv(1'b1,1'b0,1'b0,6'h00,1'b1,32'h55,1'b0,2'b00,5'd0,5'd0,1'b1, 1'b0,1'b0,5'd0,32'h0,1'b0,5'd0,1'b0, 1'b0);

    rst_ni = 1'b0; flush_i = 1'b0; trk_valid_i = 1'b0; trk_data_i = '0;
    resp_valid_i = 1'b0; resp_data_i = '0; resp_err_i = 1'b0;
    waw_req_i = '0; waw_addr0_i = '0; waw_addr1_i = '0; rf_gnt_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;

    for (int k = 0; k < 19; k++) step($sformatf("vec%0d", k), tbl[k]);

    // Back-to-back: regs 1..4 with grant tied high, one write per cycle.
    for (int k = 0; k <= 4; k++) begin
      logic [5:0]  td;
      logic [4:0]  wa;
      logic [31:0] rd;
      logic [31:0] wd;
      td = {1'b1, 5'(k + 1)};
      rd = 32'hA000_0000 + 32'(k + 1);
      wa = 5'(k);
      wd = 32'hA000_0000 + 32'(k);
      step($sformatf("b2b%0d", k),
           mkv(1'b1,1'b0,(k < 4),td,(k < 4),rd,1'b0,2'b00,5'd0,5'd0,1'b1,
               (k < 4),(k > 0),wa,wd,(k > 0),wa,1'b0,1'b0));
    end
    step("b2b_idle", mkv(1'b1,1'b0,1'b0,6'h00,1'b0,32'h0,1'b0,2'b00,5'd0,5'd0,1'b1,
                         1'b0,1'b0,5'd0,32'h0,1'b0,5'd0,1'b0,1'b0));

    // Held r9 superseded while waiting for a grant.
    step("waw_acc",  mkv(1'b1,1'b0,1'b1,6'h29,1'b1,32'h99999999,1'b0,2'b00,5'd0,5'd0,1'b0,
                         1'b1,1'b0,5'd0,32'h0,1'b0,5'd0,1'b0,1'b0));
    step("waw_w0",   mkv(1'b1,1'b0,1'b1,6'h2A,1'b1,32'h0,1'b0,2'b00,5'd0,5'd0,1'b0,
                         1'b0,1'b1,5'd9,32'h99999999,1'b0,5'd0,1'b0,1'b0));
    step("waw_w1",   mkv(1'b1,1'b0,1'b0,6'h00,1'b0,32'h0,1'b0,2'b11,5'd5,5'd8,1'b0,
                         1'b0,1'b1,5'd9,32'h99999999,1'b0,5'd0,1'b0,1'b0));
    step("waw_w2",   mkv(1'b1,1'b0,1'b0,6'h00,1'b0,32'h0,1'b0,2'b00,5'd0,5'd0,1'b0,
                         1'b0,1'b1,5'd9,32'h99999999,1'b0,5'd0,1'b0,1'b0));
    step("waw_hit",  mkv(1'b1,1'b0,1'b0,6'h00,1'b0,32'h0,1'b0,2'b10,5'd0,5'd9,1'b0,
                         1'b0,1'b1,5'd9,32'h99999999,1'b0,5'd0,1'b0,1'b0));
    step("waw_drop", mkv(1'b1,1'b0,1'b0,6'h00,1'b0,32'h0,1'b0,2'b00,5'd0,5'd0,1'b1,
                         1'b0,1'b0,5'd0,32'h0,1'b0,5'd0,1'b0,1'b0));
    step("waw_empty",mkv(1'b1,1'b0,1'b0,6'h00,1'b0,32'h0,1'b0,2'b00,5'd0,5'd0,1'b1,
                         1'b0,1'b0,5'd0,32'h0,1'b0,5'd0,1'b0,1'b0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/waw_wb_ctrl.md
# waw_wb_ctrl

- Downstream consumer of the WaW tracking FIFO.
- Pairs each popped tracking entry (`{waw_live, rd_addr[4:0]}`) in order with the matching long-latency result response, holds it in a single output register, and drives a register-file write request plus a scoreboard-release pulse.
- Suppresses the write and release when a younger writer has superseded the entry, including while the entry is held locally after leaving the FIFO.

## Interface
- `DataW`, 32, result data width
- `clk_i` input 1 — clock
- `rst_ni` input 1 — reset; synchronous, active-low
- `flush_i` input 1 — pipeline flush; drops held entry
- `trk_valid_i` input 1 — tracking FIFO has an entry
- `trk_data_i` input 6 — tracking entry; bit 5 = waw_live, bits 4:0 = rd_addr
- `trk_rdy_o` output 1 — pop tracking FIFO
- `resp_valid_i` input 1 — result response valid
- `resp_data_i` input DataW — result data
- `resp_err_i` input 1 — result carries an error
- `resp_rdy_o` output 1 — accept response
- `waw_req_i` input 2 — younger-writer issue strobes (same bus the FIFO sees)
- `waw_addr0_i` input 5 — destination register for `waw_req_i[0]`
- `waw_addr1_i` input 5 — destination register for `waw_req_i[1]`
- `rf_we_o` output 1 — register-file write request
- `rf_waddr_o` output 5 — write address
- `rf_wdata_o` output DataW — write data
- `rf_gnt_i` input 1 — write port granted this cycle
- `sb_clr_o` output 1 — scoreboard busy-bit release pulse
- `sb_clr_addr_o` output 5 — register to release
- `err_o` output 1 — one-cycle error pulse on retire of an errored response

## Operation
- Two states, `EMPTY` and `HOLD`. The hold register contains `live`, `addr`, `data` and `err`.
- **Accept condition:** `accept = trk_valid_i & resp_valid_i & ~flush_i & (EMPTY | retire)`.
  - `trk_rdy_o = resp_rdy_o = accept`.
  - Both sides pop together; there is never a one-sided pop.
- **Need write:** `need_wr = live & ~err & (addr != 0)`.
- **Retire:**
  - `retire = HOLD & (need_wr ? rf_gnt_i : 1)`.
  - Suppressed entries retire in their first `HOLD` cycle without a grant.
- **Write request:** `rf_we_o = HOLD & need_wr`. `rf_waddr_o` and `rf_wdata_o` come from the hold register.
- **Scoreboard release:** `sb_clr_o = retire & live & (addr != 0)`, with `sb_clr_addr_o = addr`.
  - An errored live entry still releases its register.
- **Error pulse:** `err_o = retire & err`.
- **Live-flag clearing:**
  - The hold register's `live` is cleared when `waw_req_i[k]` is set and `waw_addr_k == addr`, k ∈ {0,1}.
  - This applies while in `HOLD` and not retiring.
  - It matches the FIFO's clearing rule so that a superseded entry never writes.
- **Incoming-entry masking:** the captured `live` bit is ANDed with `~waw_hit` computed on the incoming address in the same cycle.
- **Transitions:**
  - `EMPTY --accept--> HOLD`
  - `HOLD --retire & accept--> HOLD` (new entry)
  - `HOLD --retire & ~accept--> EMPTY`
  - `any --flush_i--> EMPTY`
- **Flush:** `flush_i` has priority over everything.
  - No accept and no `sb_clr_o` / `err_o` in the flush cycle.
  - `rf_we_o` may be asserted in that cycle, but a grant on it is ignored.

## Timing
- All outputs reset to 0 and the state resets to `EMPTY`. Reset is sampled at `posedge clk_i` when `rst_ni = 0`.
- **Latency:** accept in cycle N, so `rf_we_o` is first asserted in N+1.
  - `sb_clr_o` is asserted in the grant cycle.
  - A suppressed entry retires in N+1.
- **Throughput:** 1 entry per cycle when `rf_gnt_i` is held high (accept on retire).
- **Holding stable:** `rf_we_o`, `rf_waddr_o` and `rf_wdata_o` stay stable until granted. A `live` drop while waiting deasserts `rf_we_o` and retires the entry that cycle.
- **Reset mid-`HOLD`:** the entry is discarded and no release pulse is issued.

## Structure
- Shared package `waw_pkg`:
  - `RegAddrW = 5`, `TrkW = 6`, `WawLiveBit = 5`
  - typedef `trk_entry_t` (packed `{live, addr}`)
  - function `waw_hit(req, a0, a1, addr)`
- The FIFO adopts the same package.
- No sub-module; the hold register and control are about 150 lines inline.

## Test plan
- **Basic write:** trk=`{1,5'd7}`, resp=`0xDEADBEEF`, `rf_gnt_i` = 1.
  - Cycle N+1: `rf_we_o` = 1, `rf_waddr_o` = 7, `rf_wdata_o` = `0xDEADBEEF`, `sb_clr_o` = 1, `sb_clr_addr_o` = 7.
- **Superseded on entry:** trk=`{0,5'd3}`.
  - N+1: `rf_we_o` = 0, `sb_clr_o` = 0, retire; `trk_rdy_o` may accept the next entry in N+1.
- **WaW while holding:** hold `{1,5'd9}` with `rf_gnt_i` = 0 for 3 cycles, then `waw_req_i` = 2'b10, `waw_addr1_i` = 9.
  - Next cycle: `rf_we_o` = 0, no `sb_clr_o`, state `EMPTY`.
- **Error response:** trk=`{1,5'd4}`, `resp_err_i` = 1.
  - N+1: `err_o` = 1, `sb_clr_o` = 1, `sb_clr_addr_o` = 4, `rf_we_o` = 0.
- **Back-to-back pops:** 4 pairs to regs 1–4 with `rf_gnt_i` tied high.
  - 4 consecutive write cycles in order, with no bubbles.
- **Flush and reset:** `flush_i` while holding `{1,5'd12}` with `rf_gnt_i` = 1 → no `sb_clr_o`, state `EMPTY`, `trk_rdy_o` = 0 that cycle.
  - Repeat with `rst_ni` = 0 → all outputs 0 the next cycle.
